// File: rtl/pmu_ahb_cfg_seq.sv
// rtl/pmu_ahb_cfg_seq.sv - AHB-lite master that programs the PMU register bank from a captured word array.
// Optional readback/compare pass: define CFG_SEQ_READBACK_EN.
module pmu_ahb_cfg_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          N_REGS    = 10,
  parameter int          REG_WIDTH = 32,
  localparam int         IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic [N_REGS*REG_WIDTH-1:0] cfg_data_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        mismatch_o,
  output logic [IDX_W-1:0]            mismatch_idx_o,
  output logic [31:0]                 haddr_o,
  output logic [1:0]                  htrans_o,
  output logic                        hwrite_o,
  output logic [2:0]                  hsize_o,
  output logic [2:0]                  hburst_o,
  output logic [3:0]                  hprot_o,
  output logic                        hmastlock_o,
  output logic [31:0]                 hwdata_o,
  input  logic                        hready_i,
  input  logic [1:0]                  hresp_i,
  input  logic [31:0]                 hrdata_i
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_DATA,
    S_FIN
  } state_t;

  state_t                        state_q;
  logic [N_REGS*REG_WIDTH-1:0]   cfg_q;
  logic [IDX_W-1:0]              idx_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          err_q;
  logic [31:0]                   haddr_q;
  logic [1:0]                    htrans_q;
  logic                          hwrite_q;
  logic [31:0]                   hwdata_q;

  logic [IDX_W-1:0]              idx_nxt_d;
  logic [31:0]                   addr_nxt_d;
  logic [REG_WIDTH-1:0]          word_d;
  logic                          last_d;
  logic                          err_now_d;

  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + {{(30-IDX_W){1'b0}}, i, 2'b00};
  endfunction

  always_comb begin
    idx_nxt_d  = idx_q + IDX_W'(1);
    addr_nxt_d = word_addr(idx_nxt_d);
    word_d     = cfg_q[REG_WIDTH*idx_q +: REG_WIDTH];
    last_d     = (idx_q == IDX_W'(N_REGS - 1));
    // An ERROR seen in any cycle of the current data phase aborts the sequence.
    err_now_d  = err_q | hresp_i[0];
  end

`ifdef CFG_SEQ_READBACK_EN
  logic             mis_q;
  logic [IDX_W-1:0] mis_idx_q;
  logic             unused_ok;
  assign unused_ok      = hresp_i[1];
  assign mismatch_o     = mis_q;
  assign mismatch_idx_o = mis_idx_q;
`else
  logic unused_ok;
  assign unused_ok      = hresp_i[1] ^ (^hrdata_i);
  assign mismatch_o     = 1'b0;
  assign mismatch_idx_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      haddr_q   <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
`ifdef CFG_SEQ_READBACK_EN
      mis_q     <= 1'b0;
      mis_idx_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cfg_q    <= cfg_data_i;
            err_q    <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            htrans_q <= HTRANS_NONSEQ;
            haddr_q  <= BASE_ADDR;
            hwrite_q <= 1'b1;
            state_q  <= S_WR_ADDR;
`ifdef CFG_SEQ_READBACK_EN
            mis_q     <= 1'b0;
            mis_idx_q <= '0;
`endif
          end
        end
        S_WR_ADDR: begin
          if (hready_i) begin
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= word_d;
            state_q  <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (hresp_i[0]) err_q <= 1'b1;
          if (hready_i) begin
            if (err_now_d) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else if (last_d) begin
`ifdef CFG_SEQ_READBACK_EN
              idx_q    <= '0;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= BASE_ADDR;
              hwrite_q <= 1'b0;
              state_q  <= S_RD_ADDR;
`else
              done_q  <= 1'b1;
              state_q <= S_FIN;
`endif
            end else begin
              idx_q    <= idx_nxt_d;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= addr_nxt_d;
              state_q  <= S_WR_ADDR;
            end
          end
        end
`ifdef CFG_SEQ_READBACK_EN
        S_RD_ADDR: begin
          if (hready_i) begin
            htrans_q <= HTRANS_IDLE;
            state_q  <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (hresp_i[0]) err_q <= 1'b1;
          if (hready_i) begin
            if (err_now_d) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              // Only the first differing register is reported.
              if (hrdata_i != word_d && !mis_q) begin
                mis_q     <= 1'b1;
                mis_idx_q <= idx_q;
              end
              if (last_d) begin
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end else begin
                idx_q    <= idx_nxt_d;
                htrans_q <= HTRANS_NONSEQ;
                haddr_q  <= addr_nxt_d;
                state_q  <= S_RD_ADDR;
              end
            end
          end
        end
`endif
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          htrans_q <= HTRANS_IDLE;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign haddr_o     = haddr_q;
  assign htrans_o    = htrans_q;
  assign hwrite_o    = hwrite_q;
  assign hwdata_o    = hwdata_q;
  assign hsize_o     = 3'b010;
  assign hburst_o    = 3'b000;
  assign hprot_o     = 4'b0011;
  assign hmastlock_o = 1'b0;

endmodule

// File: tb/tb_pmu_ahb_cfg_seq.sv
// tb/tb_pmu_ahb_cfg_seq.sv - table-driven bench for pmu_ahb_cfg_seq with a small AHB-lite memory slave.
// Expected latencies and log lengths follow the CFG_SEQ_READBACK_EN setting of the build.
module tb_pmu_ahb_cfg_seq;

  localparam logic [31:0] BASE = 32'h80000100;
`ifdef CFG_SEQ_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int NB = RB ? 8 : 4;

  logic         clk = 1'b0;
  logic         rstn_i;
  logic         start_i;
  logic [127:0] cfg_data_i;
  logic         busy_o, done_o, err_o, mismatch_o;
  logic [1:0]   mismatch_idx_o;
  logic [31:0]  haddr_o;
  logic [1:0]   htrans_o;
  logic         hwrite_o;
  logic [2:0]   hsize_o, hburst_o;
  logic [3:0]   hprot_o;
  logic         hmastlock_o;
  logic [31:0]  hwdata_o;
  logic         hready_i;
  logic [1:0]   hresp_i;
  logic [31:0]  hrdata_i;

  pmu_ahb_cfg_seq #(.BASE_ADDR(BASE), .N_REGS(4), .REG_WIDTH(32)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .cfg_data_i(cfg_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .mismatch_o(mismatch_o),
    .mismatch_idx_o(mismatch_idx_o), .haddr_o(haddr_o), .htrans_o(htrans_o),
    .hwrite_o(hwrite_o), .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o),
    .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o), .hready_i(hready_i),
    .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } tr_t;

  typedef struct {
    logic [3:0][31:0] w;
    int waitc, err_idx, force_idx, pulse_at;
    int exp_lat, exp_err, exp_mis, exp_midx, exp_nlog;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Slave configuration, set by the test process only.
  int s_wait = 0;
  int s_err_idx = -1;
  int s_force_idx = -1;

  // Slave state, owned by the slave process only.
  logic        dp_active = 1'b0;
  logic        dp_write = 1'b0;
  logic        dp_first = 1'b0;
  logic [31:0] dp_addr = '0;
  int          dp_wait = 0;
  logic [31:0] hold = '0;
  logic [31:0] mem [4];
  int          stab_err = 0;
  int          done_cnt = 0;
  tr_t         tlog [$];
  logic [1:0]  dp_idx;

  assign dp_idx   = dp_addr[3:2];
  assign hready_i = !dp_active || (dp_wait == 0);
  assign hresp_i  = (dp_active && dp_write && int'(dp_idx) == s_err_idx) ? 2'b01 : 2'b00;
  assign hrdata_i = (dp_active && !dp_write) ?
                    ((int'(dp_idx) == s_force_idx) ? 32'h0000DEAD : mem[dp_idx]) : 32'h0;

  always @(posedge clk) begin
    if (done_o) done_cnt <= done_cnt + 1;
    if (dp_active) begin
      if (dp_write) begin
        if (dp_first) hold <= hwdata_o;
        else if (hwdata_o !== hold) stab_err <= stab_err + 1;
      end
      dp_first <= 1'b0;
      if (hready_i) begin
        tlog.push_back({dp_write, dp_addr, (dp_write ? hwdata_o : hrdata_i), hresp_i[0]});
        if (dp_write) mem[dp_idx] <= hwdata_o;
        dp_active <= 1'b0;
      end else begin
        dp_wait <= dp_wait - 1;
      end
    end
    if (htrans_o == 2'b10 && hready_i) begin
      dp_active <= 1'b1;
      dp_first  <= 1'b1;
      dp_addr   <= haddr_o;
      dp_write  <= hwrite_o;
      dp_wait   <= (hwrite_o && int'(haddr_o[3:2]) == s_err_idx) ? 1 : s_wait;
    end
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input int waitc, input int err_idx, input int force_idx,
                              input int pulse_at, input int exp_lat, input int exp_err,
                              input int exp_mis, input int exp_midx, input int exp_nlog);
    vec_t v;
    v.w = {w3, w2, w1, w0};
    v.waitc = waitc; v.err_idx = err_idx; v.force_idx = force_idx; v.pulse_at = pulse_at;
    v.exp_lat = exp_lat; v.exp_err = exp_err; v.exp_mis = exp_mis;
    v.exp_midx = exp_midx; v.exp_nlog = exp_nlog;
    return v;
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    int   lat;
    int   log_base;
    int   done_base;
    int   stab_base;
    tr_t  exp_tr;
    s_wait = v.waitc; s_err_idx = v.err_idx; s_force_idx = v.force_idx;
    @(negedge clk);
    log_base = tlog.size(); done_base = done_cnt; stab_base = stab_err;
    cfg_data_i = v.w;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    cfg_data_i = {4{32'hBAD0BAD0}};
    lat = -1;
    for (int c = 1; c <= 300 && lat < 0; c++) begin
      @(negedge clk);
      start_i = (c == v.pulse_at);
      if (done_o) lat = c;
    end
    @(negedge clk);
    start_i = 1'b0;
    chk($sformatf("v%0d done_latency", n), 72'(lat), 72'(v.exp_lat));
    chk($sformatf("v%0d busy_fall", n), 72'(busy_o), 72'(0));
    chk($sformatf("v%0d done_one_cycle", n), 72'(done_o), 72'(0));
    chk($sformatf("v%0d err", n), 72'(err_o), 72'(v.exp_err));
    chk($sformatf("v%0d mismatch", n), 72'(mismatch_o), 72'(v.exp_mis));
    chk($sformatf("v%0d mismatch_idx", n), 72'(mismatch_idx_o), 72'(v.exp_midx));
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d stays_idle", n), 72'({busy_o, htrans_o}), 72'(0));
    chk($sformatf("v%0d done_count", n), 72'(done_cnt - done_base), 72'(1));
    chk($sformatf("v%0d hwdata_stable", n), 72'(stab_err - stab_base), 72'(0));
    chk($sformatf("v%0d beats", n), 72'(tlog.size() - log_base), 72'(v.exp_nlog));
    for (int k = 0; k < v.exp_nlog && log_base + k < tlog.size(); k++) begin
      if (k < 4) begin
        exp_tr = {1'b1, BASE + 32'(4*k), v.w[k], (k == v.err_idx)};
      end else begin
        exp_tr = {1'b0, BASE + 32'(4*(k-4)),
                  ((k-4) == v.force_idx) ? 32'h0000DEAD : v.w[k-4], 1'b0};
      end
      chk($sformatf("v%0d beat%0d", n, k), 72'(tlog[log_base + k]), 72'(exp_tr));
    end
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = mk(32'h1, 32'h2, 32'h3, 32'h4, 0, -1, -1, -1, 1 + 2*NB, 0, 0, 0, NB);
    tbl[1] = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000, 32'h0000FFFF,
                3, -1, -1, 3, 1 + 5*NB, 0, 0, 0, NB);
    tbl[2] = mk(32'h11, 32'h22, 32'h33, 32'h44, 0, 1, -1, -1, 6, 1, 0, 0, 2);
    tbl[3] = mk(32'h1, 32'h2, 32'h3, 32'h4, 0, -1, 2, 1 + 2*NB, 1 + 2*NB, 0, RB, 2*RB, NB);
    tbl[4] = mk(32'hDEADBEEF, 32'h0, 32'h12345678, 32'h80000001,
                1, -1, -1, -1, 1 + 3*NB, 0, 0, 0, NB);

    rstn_i = 1'b0; start_i = 1'b0; cfg_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst busy_done_err", 72'({busy_o, done_o, err_o}), 72'(0));
    chk("rst mismatch", 72'({mismatch_o, mismatch_idx_o}), 72'(0));
    chk("rst htrans", 72'(htrans_o), 72'(0));
    chk("rst haddr_hwdata_hwrite", 72'({haddr_o, hwdata_o, hwrite_o}), 72'(0));
    chk("const hsize_hburst", 72'({hsize_o, hburst_o}), 72'(6'b010_000));
    chk("const hprot_hmastlock", 72'({hprot_o, hmastlock_o}), 72'(5'b0011_0));
    rstn_i = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i, tbl[i]);

    // Reset in the data phase of beat 1 aborts without a done pulse.
    s_wait = 0; s_err_idx = -1; s_force_idx = -1;
    @(negedge clk);
    cfg_data_i = tbl[0].w;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    begin
      int done_base;
      done_base = done_cnt;
      repeat (4) @(negedge clk);
      chk("rstmid in_beat1_data", 72'({htrans_o, haddr_o}), 72'({2'b00, BASE + 32'h4}));
      rstn_i = 1'b0;
      @(negedge clk);
      chk("rstmid htrans_idle", 72'(htrans_o), 72'(0));
      chk("rstmid busy_low", 72'({busy_o, done_o}), 72'(0));
      rstn_i = 1'b1;
      repeat (12) @(negedge clk);
      chk("rstmid no_done", 72'(done_cnt - done_base), 72'(0));
    end
    run_vec(5, tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
